// File: rtl/pc_gen_pkg.sv
// Types shared by the PC generator and its redirect arbiter.
package pc_gen_pkg;
`include "core_defines.vh"

    localparam int ADDR_W = `ADDR_WIDTH;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        ST_BOOT = `PC_ST_BOOT,
        ST_RUN  = `PC_ST_RUN,
        ST_HOLD = `PC_ST_HOLD
    } pc_state_e;

    typedef enum logic [1:0] {
        RDR_NONE = `RCLS_NONE,
        RDR_JAL  = `RCLS_JAL,
        RDR_MISP = `RCLS_MISP,
        RDR_TRAP = `RCLS_TRAP
    } rdr_cls_e;

    typedef struct packed {
        rdr_cls_e cls;
        addr_t    target;
    } redirect_t;

endpackage

// File: rtl/core_defines.vh
// Shared core-wide widths and encodings for the fetch front end.
`ifndef CORE_DEFINES_VH
`define CORE_DEFINES_VH

`define ADDR_WIDTH   32

`define PC_ST_BOOT   2'd0
`define PC_ST_RUN    2'd1
`define PC_ST_HOLD   2'd2

// Redirect classes are ordered so a larger code means higher priority
`define RCLS_NONE    2'd0
`define RCLS_JAL     2'd1
`define RCLS_MISP    2'd2
`define RCLS_TRAP    2'd3

`endif

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect mux plus the pending redirect captured during a stall.
module pc_redirect_arb
    import pc_gen_pkg::*;
(
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                boot,
    input  logic                holding,
    input  logic                fetch_stall,
    input  logic                trap_valid,
    input  logic [ADDR_W-1:0]   trap_pc,
    input  logic                mispredict_ex,
    input  logic [ADDR_W-1:0]   redirect_pc_ex,
    input  logic                jal_dec,
    input  logic [ADDR_W-1:0]   jal_target_dec,
    output redirect_t           redir
);

    redirect_t live;
    redirect_t pend;
    logic      take;

    always_comb begin
        live = '{cls: RDR_NONE, target: '0};
        if (trap_valid)
            live = '{cls: RDR_TRAP, target: trap_pc};
        else if (mispredict_ex)
            live = '{cls: RDR_MISP, target: redirect_pc_ex};
        else if (jal_dec)
            live = '{cls: RDR_JAL, target: jal_target_dec};
    end

    // On release the pending redirect wins unless a strictly higher class arrives
    always_comb begin
        redir = live;
        if (holding && (live.cls <= pend.cls))
            redir = pend;
    end

    // A JAL seen while something is pending is on the wrong path, so it never replaces it
    always_comb begin
        take = (live.cls == RDR_TRAP)
            || ((live.cls != RDR_NONE) && (pend.cls == RDR_NONE))
            || ((live.cls == RDR_MISP) && (pend.cls == RDR_JAL));
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || boot) begin
            pend <= '{cls: RDR_NONE, target: '0};
        end else if (fetch_stall) begin
            if (take)
                pend <= live;
        end else begin
            pend <= '{cls: RDR_NONE, target: '0};
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: boot/run/hold FSM, pc register and redirect replay.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,
    input  logic                fetch_stall,
    input  logic                predict_taken,
    input  logic [ADDR_W-1:0]   predict_target_pc,
    input  logic                trap_valid,
    input  logic [ADDR_W-1:0]   trap_pc,
    input  logic                mispredict_ex,
    input  logic [ADDR_W-1:0]   redirect_pc_ex,
    input  logic                jal_dec,
    input  logic [ADDR_W-1:0]   jal_target_dec,
    output logic [ADDR_W-1:0]   next_pc,
    output logic [ADDR_W-1:0]   pc,
    output logic                pc_valid,
    output logic                pc_predicted_taken,
    output logic                flush_if
);

    pc_state_e state;
    redirect_t redir;
    logic      apply_redir;

    pc_redirect_arb u_arb (
        .cpu_clk        (cpu_clk),
        .cpu_rst        (cpu_rst),
        .boot           (state == ST_BOOT),
        .holding        (state == ST_HOLD),
        .fetch_stall    (fetch_stall),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .mispredict_ex  (mispredict_ex),
        .redirect_pc_ex (redirect_pc_ex),
        .jal_dec        (jal_dec),
        .jal_target_dec (jal_target_dec),
        .redir          (redir)
    );

    assign apply_redir        = (state != ST_BOOT) && !fetch_stall && (redir.cls != RDR_NONE);
    assign pc_predicted_taken = predict_taken & pc_valid;

    // Holding pc on a stall makes the BHT re-read the same index
    always_comb begin
        next_pc = pc + 32'd4;
        if (state == ST_BOOT)
            next_pc = RESET_VECTOR;
        else if (fetch_stall)
            next_pc = pc;
        else if (apply_redir)
            next_pc = redir.target;
        else if (predict_taken && pc_valid)
            next_pc = predict_target_pc;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state    <= ST_BOOT;
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
            flush_if <= 1'b0;
        end else begin
            pc       <= next_pc;
            pc_valid <= 1'b1;
            flush_if <= apply_redir;
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN:  if (fetch_stall && (redir.cls != RDR_NONE)) state <= ST_HOLD;
                ST_HOLD: if (!fetch_stall) state <= ST_RUN;
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Randomized and directed check of pc_gen against a spec-level reference model.
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        fetch_stall, predict_taken, trap_valid, mispredict_ex, jal_dec;
    logic [31:0] predict_target_pc, trap_pc, redirect_pc_ex, jal_target_dec;
    logic [31:0] next_pc, pc;
    logic        pc_valid, pc_predicted_taken, flush_if;

    int n_chk = 0;
    int n_err = 0;

    // reference state: fetch pc, valid, flush, boot cycle, pending class (0..3) and target
    logic [31:0] m_pc, p_tgt;
    logic        m_valid, m_flush, m_boot;
    int          p_cls;

    always #5 cpu_clk = ~cpu_clk;

    pc_gen #(.RESET_VECTOR(RV)) dut (
        .cpu_clk            (cpu_clk),
        .cpu_rst            (cpu_rst),
        .fetch_stall        (fetch_stall),
        .predict_taken      (predict_taken),
        .predict_target_pc  (predict_target_pc),
        .trap_valid         (trap_valid),
        .trap_pc            (trap_pc),
        .mispredict_ex      (mispredict_ex),
        .redirect_pc_ex     (redirect_pc_ex),
        .jal_dec            (jal_dec),
        .jal_target_dec     (jal_target_dec),
        .next_pc            (next_pc),
        .pc                 (pc),
        .pc_valid           (pc_valid),
        .pc_predicted_taken (pc_predicted_taken),
        .flush_if           (flush_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        cpu_rst = 0; fetch_stall = 0; predict_taken = 0; trap_valid = 0;
        mispredict_ex = 0; jal_dec = 0;
        predict_target_pc = 0; trap_pc = 0; redirect_pc_ex = 0; jal_target_dec = 0;
    endtask

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        return {a[31:2], 2'b00};
    endfunction

    // One cycle: compare all outputs to the model mid-cycle, then advance the model at the edge
    task automatic tick();
        int          lc;
        logic [31:0] lt, nx;
        logic        fl;
        #4;
        lc = 0; lt = 0;
        if (trap_valid)         begin lc = 3; lt = trap_pc;        end
        else if (mispredict_ex) begin lc = 2; lt = redirect_pc_ex; end
        else if (jal_dec)       begin lc = 1; lt = jal_target_dec; end
        fl = 0;
        if (m_boot)                        nx = RV;
        else if (fetch_stall)              nx = m_pc;
        else if (lc > p_cls)               begin nx = lt;    fl = 1; end
        else if (p_cls > 0)                begin nx = p_tgt; fl = 1; end
        else if (predict_taken && m_valid) nx = predict_target_pc;
        else                               nx = m_pc + 32'd4;
        chk("pc", pc, m_pc);
        chk("pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
        chk("flush_if", {31'b0, flush_if}, {31'b0, m_flush});
        chk("pred_taken", {31'b0, pc_predicted_taken}, {31'b0, predict_taken & m_valid});
        chk("next_pc", next_pc, nx);
        @(posedge cpu_clk);
        if (cpu_rst) begin
            m_pc = RV; m_valid = 0; m_flush = 0; m_boot = 1; p_cls = 0;
        end else begin
            if (m_boot || !fetch_stall) p_cls = 0;
            else if (lc == 3 || (lc > 0 && p_cls == 0) || (lc == 2 && p_cls == 1)) begin
                p_cls = lc; p_tgt = lt;
            end
            m_pc = nx; m_valid = 1; m_flush = fl; m_boot = 0;
        end
        #1;
    endtask

    initial begin
        logic [31:0] held;
        idle();
        cpu_rst = 1;
        @(posedge cpu_clk); #1;
        m_pc = RV; m_valid = 0; m_flush = 0; m_boot = 1; p_cls = 0; p_tgt = 0;

        // boot sequence: RV invalid, RV valid, then +4
        idle(); tick();
        chk("boot_pc", pc, RV); chk("boot_valid", {31'b0, pc_valid}, 32'd1);
        tick(); chk("seq_pc4", pc, 32'h4);
        tick(); chk("seq_pc8", pc, 32'h8);

        // predicted-taken from 0x100
        jal_dec = 1; jal_target_dec = 32'h100; tick(); idle();
        predict_taken = 1; predict_target_pc = 32'h200; #1;
        chk("pt_pred", {31'b0, pc_predicted_taken}, 32'd1);
        tick(); idle();
        chk("pt_pc", pc, 32'h200); chk("pt_flush", {31'b0, flush_if}, 32'd0);

        // all sources at once: trap wins
        trap_valid = 1; trap_pc = 32'h8000; mispredict_ex = 1; redirect_pc_ex = 32'h300;
        jal_dec = 1; jal_target_dec = 32'h400; predict_taken = 1; predict_target_pc = 32'h200;
        tick(); idle();
        chk("prio_pc", pc, 32'h8000); chk("prio_flush", {31'b0, flush_if}, 32'd1);
        tick();

        // stall with captured redirects and overwrite rules
        held = m_pc;
        fetch_stall = 1; jal_dec = 1; jal_target_dec = 32'h400; tick(); idle();
        fetch_stall = 1; mispredict_ex = 1; redirect_pc_ex = 32'h300; tick(); idle();
        fetch_stall = 1; jal_dec = 1; jal_target_dec = 32'h500; tick(); idle();
        chk("hold_pc", pc, held);
        tick();
        chk("replay_pc", pc, 32'h300); chk("replay_flush", {31'b0, flush_if}, 32'd1);
        tick();
        chk("cleared_pc", pc, 32'h304); chk("cleared_flush", {31'b0, flush_if}, 32'd0);

        // increment wrap
        jal_dec = 1; jal_target_dec = 32'hFFFF_FFFC; tick(); idle();
        tick(); chk("wrap_pc", pc, 32'h0);

        // reset while holding a trap discards it
        fetch_stall = 1; trap_valid = 1; trap_pc = 32'h8000; tick(); idle();
        cpu_rst = 1; fetch_stall = 1; tick(); idle();
        tick();
        chk("rst_hold_pc", pc, RV); chk("rst_hold_valid", {31'b0, pc_valid}, 32'd1);
        tick(); chk("rst_hold_next", pc, RV + 32'h4);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cpu_rst           = ($urandom_range(0, 299) == 0);
            fetch_stall       = ($urandom_range(0, 9) < 3);
            predict_taken     = ($urandom_range(0, 2) == 0);
            trap_valid        = ($urandom_range(0, 15) == 0);
            mispredict_ex     = ($urandom_range(0, 7) == 0);
            jal_dec           = ($urandom_range(0, 5) == 0);
            predict_target_pc = rnd_addr();
            trap_pc           = rnd_addr();
            redirect_pc_ex    = rnd_addr();
            jal_target_dec    = rnd_addr();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch-stage program counter generator, directly upstream of `branch_predict`. Each cycle it produces `next_pc`, which drives the synchronous BHT/BTT/predictor read address, and the registered `pc` that `branch_predict` compares against. It merges trap, EX-mispredict, decode-JAL and predicted-taken redirects by fixed priority. Redirects that arrive while fetch is stalled are captured and replayed so that none is lost.

## Interface
Parameters:
- `RESET_VECTOR`, 32'h0000_0000, first fetch address after reset.

Ports (widths use `` `ADDR_WIDTH `` = 32):
- `cpu_clk`  in  1  core clock; all state updates on rising edge.
- `cpu_rst`  in  1  reset, synchronous, active-high.
- `fetch_stall`  in  1  instruction memory or pipeline cannot accept a new fetch; hold `pc`.
- `predict_taken`  in  1  prediction for the current `pc`, from `branch_predict`.
- `predict_target_pc`  in  ADDR  predicted target for the current `pc`.
- `trap_valid`  in  1  trap or exception redirect from commit.
- `trap_pc`  in  ADDR  trap target.
- `mispredict_ex`  in  1  EX resolved branch or JALR disagrees with its prediction.
- `redirect_pc_ex`  in  ADDR  correct PC from EX.
- `jal_dec`  in  1  JAL decoded in DEC.
- `jal_target_dec`  in  ADDR  JAL target.
- `next_pc`  out  ADDR  combinational; address `pc` will take at the next edge.
- `pc`  out  ADDR  current fetch PC.
- `pc_valid`  out  1  `pc` is a real fetch and prediction inputs are meaningful.
- `pc_predicted_taken`  out  1  `predict_taken & pc_valid`; travels down the pipe to EX.
- `flush_if`  out  1  kill the instruction fetched at the previous `pc`.

## Operation
- Priority, highest first: trap, mispredict_ex, jal_dec, predict_taken, `pc + 4`. The increment wraps modulo 2^32.
- States:
  - BOOT is entered on reset and lasts one cycle.
  - RUN is normal operation.
  - HOLD means stalled with a redirect pending.
- BOOT:
  - `next_pc` = `RESET_VECTOR` and `pc_valid` = 0.
  - Always goes to RUN on the next edge.
  - `pc` stays `RESET_VECTOR`.
- RUN, not stalled: `next_pc` = the highest-priority source above.
- RUN, stalled with no redirect: `next_pc` = `pc`. The BHT then re-reads the same index, so the prediction stays aligned.
- RUN, stalled with a redirect: capture the target and its class into a pending register, then go to HOLD. `next_pc` = `pc`.
- HOLD, still stalled:
  - `next_pc` = `pc`.
  - A new trap overwrites any pending redirect.
  - A new mispredict overwrites a pending JAL.
  - A new JAL never overwrites a pending redirect, because it is on the wrong path.
- HOLD, stall released:
  - `next_pc` = the pending target, unless a same-cycle redirect of strictly higher class arrives; that one wins.
  - Clear the pending register and go to RUN.
- `predict_taken` is ignored when any of these hold:
  - `pc_valid` = 0
  - `fetch_stall` = 1
  - a redirect is applied this cycle
- `flush_if` = 1 in the cycle a trap, mispredict or JAL target is loaded into `pc`, whether it is live or replayed from pending. It is 0 for predicted-taken.

## Timing
- Reset values:
  - `pc` = `RESET_VECTOR`
  - `next_pc` = `RESET_VECTOR`
  - `pc_valid` = 0
  - `pc_predicted_taken` = 0
  - `flush_if` = 0
  - state = BOOT
  - pending cleared
- Reset asserted mid-HOLD discards the pending redirect.
- `pc` latency is one edge from `next_pc`. The prediction for `pc` is valid in the same cycle, because the BHT read is launched by `next_pc`.
- `pc_valid` is 1 from the second cycle after reset deassertion.
- `pc_valid` stays 1 during a stall; `pc` repeats.
- Redirect-to-fetch latency:
  - Live redirect: target appears on `next_pc` the same cycle and on `pc` at the next edge.
  - Replayed redirect: target appears on `pc` at the edge where `fetch_stall` is first sampled 0.
- `flush_if` is registered and asserted in the same cycle the redirected `pc` appears.

## Structure
- `` `ADDR_WIDTH ``, state encodings (BOOT/RUN/HOLD) and redirect class codes (NONE, JAL, MISP, TRAP) go in `core_defines.vh`.
- One sub-module, `pc_redirect_arb`, holds the priority mux plus the pending target/class register with the overwrite rules. `pc_gen` keeps the FSM, `pc` register and outputs.

## Test plan
- Reset, release, no redirects, no predictions → `pc` sequence 0x0, 0x0 (BOOT, `pc_valid`=0), then 0x4, 0x8…; `pc_valid`=1 from cycle 2.
- At `pc`=0x100, `predict_taken`=1, target 0x200 → next `pc`=0x200, `pc_predicted_taken`=1 at 0x100, `flush_if`=0.
- Same cycle: `trap_valid`=1 (0x8000), `mispredict_ex`=1 (0x300), `jal_dec`=1 (0x400), `predict_taken`=1 → `pc`=0x8000, `flush_if`=1.
- Stall 3 cycles; cycle 1 `jal_dec`→0x400, cycle 2 `mispredict_ex`→0x300, cycle 3 `jal_dec`→0x500 → `pc` held through the stall; on release `pc`=0x300 and the pending register is cleared.
- `pc`=0xFFFF_FFFC, no redirect → `pc`=0x0000_0000.
- Assert `cpu_rst` while in HOLD with a pending trap → after release `pc`=`RESET_VECTOR` via BOOT; the trap target never appears.
